// File: rtl/dm_resp_pkg.sv
// rtl/dm_resp_pkg.sv - shared encodings and helpers for the data-memory responder
package dm_resp_pkg;

    // Access size / extension encodings carried on dm_type
    typedef enum logic [2:0] {
        dm_word              = 3'b000,
        dm_halfword          = 3'b001,
        dm_halfword_unsigned = 3'b010,
        dm_byte              = 3'b011,
        dm_byte_unsigned     = 3'b100
    } dm_type_e;

    // Responder FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    // Unknown dm_type values behave as word accesses, so they share the word rule
    function automatic logic dm_misaligned(input logic [2:0] dm_type, input logic [1:0] offset);
        logic mis;
        case (dm_type)
            dm_halfword, dm_halfword_unsigned: mis = offset[0];
            dm_byte, dm_byte_unsigned:         mis = 1'b0;
            default:                           mis = (offset != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dm_resp_if.sv
// rtl/dm_resp_if.sv - CPU data-port bundle between requester and memory responder
interface dm_resp_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [2:0]  dm_type;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
    logic        err;

    modport master (
        output req, we, addr, dm_type, wdata,
        input  rdata, ack, err
    );

    modport slave (
        input  req, we, addr, dm_type, wdata,
        output rdata, ack, err
    );
endinterface

// File: rtl/dm_lane.sv
// rtl/dm_lane.sv - combinational byte-lane merge (store) and extract/extend (load)
module dm_lane
    import dm_resp_pkg::*;
(
    input  logic [31:0] word_in,
    input  logic [31:0] store_data,
    input  logic [2:0]  dm_type,
    input  logic [1:0]  offset,
    output logic [31:0] merged,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [4:0]  byte_shift;
    logic [4:0]  half_shift;

    assign byte_shift = {offset, 3'b000};
    assign half_shift = {offset[1], 4'b0000};

    // Select lanes by offset; unknown types fall through to full-word behaviour
    always_comb begin
        merged    = word_in;
        load_data = word_in;
        byte_sel  = word_in[byte_shift +: 8];
        half_sel  = word_in[half_shift +: 16];
        case (dm_type)
            dm_byte, dm_byte_unsigned: begin
                merged[byte_shift +: 8] = store_data[7:0];
                if (dm_type == dm_byte) begin
                    load_data = {{24{byte_sel[7]}}, byte_sel};
                end else begin
                    load_data = {24'b0, byte_sel};
                end
            end
            dm_halfword, dm_halfword_unsigned: begin
                merged[half_shift +: 16] = store_data[15:0];
                if (dm_type == dm_halfword) begin
                    load_data = {{16{half_sel[15]}}, half_sel};
                end else begin
                    load_data = {16'b0, half_sel};
                end
            end
            default: begin
                merged    = store_data;
                load_data = word_in;
            end
        endcase
    end

endmodule

// File: rtl/dm_resp.sv
// rtl/dm_resp.sv - multi-cycle data-memory responder with wait states and lane logic
module dm_resp
    import dm_resp_pkg::*;
#(
    parameter int ADDR_WIDTH  = 7,
    parameter int WAIT_CYCLES = 2
) (
    input  logic      clk,
    input  logic      reset,
    dm_resp_if.slave  bus
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [3:0] WAIT_INIT = 4'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

    state_e                  state_q,   state_d;
    logic [3:0]              cnt_q,     cnt_d;
    logic                    we_q,      we_d;
    logic [ADDR_WIDTH+1:0]   addr_q,    addr_d;
    logic [2:0]              dm_type_q, dm_type_d;
    logic [31:0]             wdata_q,   wdata_d;
    logic                    err_q,     err_d;
    logic [31:0]             rdata_q,   rdata_d;

    logic [31:0]             mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0]   word_idx;
    logic [31:0]             merged;
    logic [31:0]             load_data;
    logic                    req_misaligned;
    logic                    mem_we;
    logic                    unused_addr_hi;

    // Address bits above the word index are ignored so accesses wrap modulo depth
    assign unused_addr_hi = ^bus.addr[31:ADDR_WIDTH+2];

    assign word_idx       = addr_q[ADDR_WIDTH+1:2];
    assign req_misaligned = dm_misaligned(bus.dm_type, bus.addr[1:0]);
    assign mem_we         = (state_q == ACCESS) && we_q;

    dm_lane u_lane (
        .word_in    (mem_q[word_idx]),
        .store_data (wdata_q),
        .dm_type    (dm_type_q),
        .offset     (addr_q[1:0]),
        .merged     (merged),
        .load_data  (load_data)
    );

    // Next-state logic: latch request in IDLE, count wait states, access once, respond once
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        addr_d    = addr_q;
        dm_type_d = dm_type_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        rdata_d   = rdata_q;
        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    we_d      = bus.we;
                    addr_d    = bus.addr[ADDR_WIDTH+1:0];
                    dm_type_d = bus.dm_type;
                    wdata_d   = bus.wdata;
                    err_d     = req_misaligned;
                    if (req_misaligned) begin
                        rdata_d = '0;
                        state_d = RESP;
                    end else if (WAIT_CYCLES == 0) begin
                        state_d = ACCESS;
                    end else begin
                        cnt_d   = WAIT_INIT;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ACCESS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ACCESS: begin
                // Stores leave rdata untouched; only loads refresh it
                if (!we_q) begin
                    rdata_d = load_data;
                end
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and response registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            dm_type_q <= 3'b000;
            wdata_q   <= 32'b0;
            err_q     <= 1'b0;
            rdata_q   <= 32'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            dm_type_q <= dm_type_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
        end
    end

    // Storage is never cleared; a reset forces IDLE so an abandoned store never commits
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[word_idx] <= merged;
        end
    end

    assign bus.ack   = (state_q == RESP);
    assign bus.err   = err_q && (state_q == RESP);
    assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_dm_resp.sv
// tb/tb_dm_resp.sv - scoreboard bench for dm_resp with a behavioural memory model
module tb_dm_resp;
    import dm_resp_pkg::*;

    localparam int AW    = 7;
    localparam int W0    = 2;
    localparam int W1    = 0;
    localparam int DEPTH = 1 << AW;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dm_resp_if bus0 ();
    dm_resp_if bus1 ();

    dm_resp #(.ADDR_WIDTH(AW), .WAIT_CYCLES(W0)) u_dut0 (.clk(clk), .reset(reset), .bus(bus0));
    dm_resp #(.ADDR_WIDTH(AW), .WAIT_CYCLES(W1)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          issue;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [31:0] mdl_mem0 [DEPTH];
    logic [31:0] mdl_mem1 [DEPTH];
    logic [31:0] last_rd [2];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int acc_size(input logic [2:0] t);
        if (t == dm_halfword || t == dm_halfword_unsigned) return 2;
        if (t == dm_byte || t == dm_byte_unsigned) return 1;
        return 4;
    endfunction

    function automatic logic [31:0] mdl_load(input logic [31:0] w, input logic [2:0] t, input logic [1:0] off);
        logic [31:0] v;
        v = w >> (8 * int'(off));
        if (acc_size(t) == 1) begin
            v = v & 32'h0000_00FF;
            if (t == dm_byte && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (acc_size(t) == 2) begin
            v = v & 32'h0000_FFFF;
            if (t == dm_halfword && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] mdl_store(input logic [31:0] w, input logic [31:0] d,
                                              input logic [2:0] t, input logic [1:0] off);
        for (int i = 0; i < acc_size(t); i++) begin
            w[8 * (int'(off) + i) +: 8] = d[8 * i +: 8];
        end
        return w;
    endfunction

    task automatic drive(input int d, input logic r, input logic w, input logic [31:0] a,
                         input logic [2:0] t, input logic [31:0] wd);
        if (d == 0) begin
            bus0.req = r; bus0.we = w; bus0.addr = a; bus0.dm_type = t; bus0.wdata = wd;
        end else begin
            bus1.req = r; bus1.we = w; bus1.addr = a; bus1.dm_type = t; bus1.wdata = wd;
        end
    endtask

    task automatic check_ack(input int d, input logic [31:0] rd, input logic er);
        exp_t e;
        checks++;
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            errors++;
            $display("FAIL spurious_ack dut%0d: ack=1 with no request outstanding, required ack=0", d);
            return;
        end
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        if (rd !== e.rdata) begin
            errors++;
            $display("FAIL rdata dut%0d: got %08h expected %08h", d, rd, e.rdata);
        end
        checks++;
        if (er !== e.err) begin
            errors++;
            $display("FAIL err dut%0d: got %0b expected %0b", d, er, e.err);
        end
        checks++;
        if (cyc - e.issue != e.lat) begin
            errors++;
            $display("FAIL latency dut%0d: got %0d expected %0d", d, cyc - e.issue, e.lat);
        end
    endtask

    // Monitor: every ack is compared against the oldest expected response
    always @(negedge clk) begin
        if (!reset && bus0.ack === 1'b1) check_ack(0, bus0.rdata, bus0.err);
        if (!reset && bus1.ack === 1'b1) check_ack(1, bus1.rdata, bus1.err);
    end

    task automatic issue(input int d, input logic w, input logic [31:0] a,
                         input logic [2:0] t, input logic [31:0] wd);
        exp_t e;
        int   idx;
        int   n;
        logic mis;
        logic got;
        @(negedge clk);
        mis = (int'(a[1:0]) % acc_size(t)) != 0;
        idx = int'(a[AW+1:2]);
        e.err = mis;
        if (mis) begin
            last_rd[d] = 32'h0;
            e.lat      = 1;
        end else begin
            e.lat = ((d == 0) ? W0 : W1) + 2;
            if (w) begin
                if (d == 0) mdl_mem0[idx] = mdl_store(mdl_mem0[idx], wd, t, a[1:0]);
                else        mdl_mem1[idx] = mdl_store(mdl_mem1[idx], wd, t, a[1:0]);
            end else begin
                last_rd[d] = mdl_load((d == 0) ? mdl_mem0[idx] : mdl_mem1[idx], t, a[1:0]);
            end
        end
        e.rdata = last_rd[d];
        e.issue = cyc;
        if (d == 0) q0.push_back(e); else q1.push_back(e);
        drive(d, 1'b1, w, a, t, wd);
        @(posedge clk);
        #1;
        drive(d, 1'b1, 1'($urandom), $urandom, 3'($urandom_range(0, 7)), $urandom);
        n   = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            got = (d == 0) ? (bus0.ack === 1'b1) : (bus1.ack === 1'b1);
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout dut%0d: no ack within %0d cycles, required ack=1", d, n);
            if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
        @(posedge clk);
        #1;
        drive(d, 1'b0, 1'b0, 32'h0, 3'b000, 32'h0);
    endtask

    task automatic expect_bit(input string name, input logic act, input logic req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", name, act, req_v);
        end
    endtask

    task automatic expect_word(input string name, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, req_v);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;
        for (int i = 0; i < DEPTH; i++) begin
            mdl_mem0[i] = 32'h0;
            mdl_mem1[i] = 32'h0;
        end
        drive(0, 1'b0, 1'b0, 32'h0, 3'b000, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 3'b000, 32'h0);
        #1;
        expect_bit("reset_ack0", bus0.ack, 1'b0);
        expect_bit("reset_err0", bus0.err, 1'b0);
        expect_word("reset_rdata0", bus0.rdata, 32'h0);
        expect_bit("reset_ack1", bus1.ack, 1'b0);
        expect_word("reset_rdata1", bus1.rdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Give DUT0 defined contents everywhere
        for (int i = 0; i < DEPTH; i++) issue(0, 1'b1, 32'(i * 4), dm_word, 32'h0);

        // Directed sequence with WAIT_CYCLES=2
        issue(0, 1'b1, 32'h10, dm_word, 32'h1234_5678);
        issue(0, 1'b0, 32'h10, dm_word, 32'h0);
        issue(0, 1'b1, 32'h11, dm_byte, 32'h0000_00AB);
        issue(0, 1'b0, 32'h10, dm_word, 32'h0);
        issue(0, 1'b0, 32'h11, dm_byte, 32'h0);
        issue(0, 1'b0, 32'h11, dm_byte_unsigned, 32'h0);
        issue(0, 1'b1, 32'h12, dm_halfword, 32'h0000_8001);
        issue(0, 1'b0, 32'h12, dm_halfword, 32'h0);
        issue(0, 1'b0, 32'h12, dm_halfword_unsigned, 32'h0);
        issue(0, 1'b0, 32'h10, dm_word, 32'h0);
        issue(0, 1'b0, 32'h13, dm_word, 32'h0);
        issue(0, 1'b1, 32'h13, dm_word, 32'hFFFF_FFFF);
        issue(0, 1'b1, 32'h11, dm_halfword, 32'hFFFF_FFFF);
        issue(0, 1'b0, 32'h10, dm_word, 32'h0);

        // Reset during the wait phase of a store abandons it
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 32'h20, dm_word, 32'hDEAD_BEEF);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 32'h0, 3'b000, 32'h0);
        #1;
        expect_bit("midreset_ack", bus0.ack, 1'b0);
        expect_bit("midreset_err", bus0.err, 1'b0);
        expect_word("midreset_rdata", bus0.rdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            expect_bit("abandoned_ack", bus0.ack, 1'b0);
        end
        issue(0, 1'b0, 32'h20, dm_word, 32'h0);

        // Zero-wait instance and address wrap
        issue(1, 1'b1, 32'h200, dm_word, 32'hCAFE_F00D);
        issue(1, 1'b0, 32'h0, dm_word, 32'h0);
        issue(1, 1'b1, 32'h3, dm_byte, 32'h0000_005A);
        issue(1, 1'b0, 32'h3, dm_byte_unsigned, 32'h0);
        issue(1, 1'b0, 32'h2, dm_word, 32'h0);
        issue(1, 1'b0, 32'h0, dm_word, 32'h0);

        // Randomized traffic, including unknown types and high address bits
        for (int i = 0; i < 150; i++) begin
            issue(0, 1'($urandom), $urandom, 3'($urandom_range(0, 7)), $urandom);
        end

        repeat (4) @(negedge clk);
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL pending: %0d/%0d responses never arrived, required 0/0", q0.size(), q1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
